ili9163_frame_gen: RTL
======================

# ili9163_frame_gen

Raster pixel source that sits directly upstream of the ILI9163 display controller. Per frame it generates WIDTH×HEIGHT RGB565 pixels in row-major order: a solid background with one rectangular sprite, all registered. It advances one pixel per request strobe from the controller. It raises `frame_done` after the last pixel, which lets the controller stop streaming. Colours and sprite position are shadow-latched at frame start, so a frame never tears.

## Interface
- WIDTH, 128, display columns
- HEIGHT, 128, display rows
- PIXEL_SIZE, 16, bits per pixel (RGB565)
- SPRITE_W, 16, sprite width in pixels
- SPRITE_H, 16, sprite height in pixels

- clk  in  1  system clock; the single clock of the block
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse that starts a new frame
- pixel_req  in  1  one-cycle pulse from the controller requesting the next pixel (controller's data strobe, already in `clk` domain)
- bg_color  in  PIXEL_SIZE  background colour, sampled at frame start
- fg_color  in  PIXEL_SIZE  sprite colour, sampled at frame start
- sprite_x  in  $clog2(WIDTH)  sprite left column, sampled at frame start
- sprite_y  in  $clog2(HEIGHT)  sprite top row, sampled at frame start
- pixel_data  out  PIXEL_SIZE  current pixel, registered
- pixel_valid  out  1  `pixel_data` holds a frame pixel
- frame_done  out  1  all pixels consumed; held high until next frame_start
- busy  out  1  frame in progress

## Operation
- States: IDLE, STREAM, DONE. The encoding is in the package.
- **IDLE**
  - Reached on reset.
  - `pixel_req` is ignored.
  - `frame_start` causes: latch bg/fg/sprite_x/sprite_y into shadow registers, set x=0, y=0, go to STREAM.
- **STREAM**
  - `pixel_data` shows the pixel at the current (x,y).
  - Each `pixel_req` advances to the next position:
    - x increments.
    - At x=WIDTH-1, x wraps to 0 and y increments.
  - The `pixel_req` taken at (WIDTH-1, HEIGHT-1) ends the frame: go to DONE.
  - `frame_start` in STREAM is ignored.
- **DONE**
  - `frame_done`=1, `pixel_valid`=0, `pixel_data` holds its last value.
  - `pixel_req` is ignored.
  - `frame_start` restarts the frame exactly as from IDLE.
  - If `frame_start` and `pixel_req` arrive in the same cycle, `frame_start` wins and the request is dropped.
- **Sprite hit**: a pixel is in the sprite when `sx ≤ x < sx+SPRITE_W` and `sy ≤ y < sy+SPRITE_H`.
  - Sums are computed one bit wider than the coordinate, so the sprite clips at the right and bottom edges.
  - The sprite never wraps to column 0 or row 0.
- Pixel colour = `fg` on a hit, else `bg`, taken from the shadow registers. Live input changes mid-frame have no effect.
- Exactly WIDTH×HEIGHT requests are consumed per frame.
- **Reset mid-operation**: immediate return to IDLE with all outputs at their reset values. A partially streamed frame is abandoned.

## Timing
- Reset values: `pixel_data`=0, `pixel_valid`=0, `frame_done`=0, `busy`=0, state=IDLE, x=y=0.
- `frame_start` sampled in cycle n:
  - In cycle n+1, `busy`=1, `pixel_valid`=1, `frame_done`=0, and `pixel_data` = pixel (0,0).
- `pixel_req` sampled in cycle n during STREAM:
  - In cycle n+1, `pixel_data` = the next pixel (one-cycle latency).
- Back-to-back `pixel_req` on every cycle is supported without loss.
- Last request, sampled in cycle n:
  - In cycle n+1, `frame_done`=1, `busy`=0, `pixel_valid`=0.
- Every output is driven from a register; there are no combinational paths from input to output.

## Structure
- Package `ili9163_pkg` holds:
  - state encoding;
  - RGB565 colour constants: BLACK 16'h0000, WHITE 16'hFFFF, RED 16'hF800, CYAN 16'h07FF;
  - the function computing coordinate width from WIDTH/HEIGHT.
- Sub-module `raster_counter`: x/y counters with advance enable, clear, and a `last` flag asserted at (WIDTH-1, HEIGHT-1).
- Top-level glue replaces the fixed-colour pixel counter currently feeding the controller. Connections:
  - `frame_done` → controller `frame_done`
  - `pixel_data` → controller `input_data`
  - controller data strobe, edge-detected into `clk`, → `pixel_req`

## Test plan
- **Reset.** Assert `rst`=0 mid-sim with outputs toggling → all outputs 0 and state IDLE within the same cycle. `pixel_req` pulses before any `frame_start` → no output change.
- **Basic frame.**
  - Stimulus: bg=16'h0000, fg=16'h07FF, sprite (10,20), then `frame_start`, then 16384 requests one per cycle.
  - Required pixels: (10,20)=07FF, (9,20)=0000, (25,35)=07FF, (26,35)=0000, (10,36)=0000.
  - After the 16384th request, `frame_done`=1 next cycle.
- **Edge clipping.** sprite (120,120): pixels x=120..127, y=120..127 are fg. Row 121, x=0..7 are bg (no wrap). Frame still ends after exactly 16384 requests.
- **Shadowing.** Change fg to 16'hF800 and sprite_x to 0 mid-frame → the remainder of the frame still uses 07FF at (10,20). A second `frame_start` in DONE applies the new values.
- **Collisions.** `frame_start` during STREAM is ignored and the pixel count continues. `frame_start` + `pixel_req` in the same DONE cycle → new frame begins at pixel (0,0), not (1,0).
- **Throttled requests.** Requests spaced with random gaps of 0–7 cycles → pixel sequence identical to the back-to-back case, and `pixel_data` is stable between requests.

Source files
------------

// File: rtl/ili9163_pkg.sv
// Shared definitions for the ILI9163 raster pixel source: FSM encoding,
// RGB565 colour constants and coordinate-width helper.
package ili9163_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [15:0] BLACK = 16'h0000;
   localparam logic [15:0] WHITE = 16'hFFFF;
   localparam logic [15:0] RED   = 16'hF800;
   localparam logic [15:0] CYAN  = 16'h07FF;

   function automatic int coord_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major x/y position counter; also exposes the position one advance ahead
// so the pixel for the next position can be registered alongside it.
module raster_counter
   import ili9163_pkg::*;
#(
   parameter  int WIDTH  = 128,
   parameter  int HEIGHT = 128,
   localparam int XW     = coord_w(WIDTH),
   localparam int YW     = coord_w(HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [XW-1:0] nx,
   output logic [YW-1:0] ny,
   output logic          last
);

   logic x_end;

   assign x_end = (x == XW'(WIDTH - 1));
   assign last  = x_end && (y == YW'(HEIGHT - 1));
   assign nx    = x_end ? '0 : x + XW'(1);
   assign ny    = last ? '0 : (x_end ? y + YW'(1) : y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         x <= nx;
         y <= ny;
      end
   end

endmodule

// File: rtl/ili9163_frame_gen.sv
// Raster pixel source for the ILI9163 controller: solid background plus one
// rectangular sprite, one pixel per request, parameters shadowed per frame.
module ili9163_frame_gen
   import ili9163_pkg::*;
#(
   parameter  int WIDTH      = 128,
   parameter  int HEIGHT     = 128,
   parameter  int PIXEL_SIZE = 16,
   parameter  int SPRITE_W   = 16,
   parameter  int SPRITE_H   = 16,
   localparam int XW         = coord_w(WIDTH),
   localparam int YW         = coord_w(HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  pixel_req,
   input  logic [PIXEL_SIZE-1:0] bg_color,
   input  logic [PIXEL_SIZE-1:0] fg_color,
   input  logic [XW-1:0]         sprite_x,
   input  logic [YW-1:0]         sprite_y,
   output logic [PIXEL_SIZE-1:0] pixel_data,
   output logic                  pixel_valid,
   output logic                  frame_done,
   output logic                  busy
);

   state_t                state_q, state_d;
   logic                  start, take;
   logic [PIXEL_SIZE-1:0] bg_q, fg_q;
   logic [XW-1:0]         sx_q;
   logic [YW-1:0]         sy_q;
   logic [XW-1:0]         cx, nx, hx, hsx;
   logic [YW-1:0]         cy, ny, hy, hsy;
   logic                  last;
   logic [PIXEL_SIZE-1:0] hbg, hfg, pix;
   logic [XW:0]           x_lim;
   logic [YW:0]           y_lim;
   logic                  hit;

   raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (start),
      .advance (take),
      .x       (cx),
      .y       (cy),
      .nx      (nx),
      .ny      (ny),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      start   = frame_start && (state_q != STREAM);
      take    = pixel_req && (state_q == STREAM);
      if (start)
         state_d = STREAM;
      else if (take && last)
         state_d = DONE;
   end

   // On frame start the first pixel is built from the live inputs being latched;
   // otherwise from the shadow copies at the position after the advance.
   always_comb begin
      hx  = start ? '0 : nx;
      hy  = start ? '0 : ny;
      hsx = start ? sprite_x : sx_q;
      hsy = start ? sprite_y : sy_q;
      hbg = start ? bg_color : bg_q;
      hfg = start ? fg_color : fg_q;
      // One bit wider than the coordinate so the sprite clips instead of wrapping.
      x_lim = {1'b0, hsx} + (XW+1)'(SPRITE_W);
      y_lim = {1'b0, hsy} + (YW+1)'(SPRITE_H);
      hit   = (hx >= hsx) && ({1'b0, hx} < x_lim) &&
              (hy >= hsy) && ({1'b0, hy} < y_lim);
      pix   = hit ? hfg : hbg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         bg_q        <= '0;
         fg_q        <= '0;
         sx_q        <= '0;
         sy_q        <= '0;
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy        <= (state_d == STREAM);
         pixel_valid <= (state_d == STREAM);
         frame_done  <= (state_d == DONE);
         if (start) begin
            bg_q       <= bg_color;
            fg_q       <= fg_color;
            sx_q       <= sprite_x;
            sy_q       <= sprite_y;
            pixel_data <= pix;
         end else if (take && !last) begin
            pixel_data <= pix;
         end
      end
   end

endmodule
